// File: rtl/pc_gen.sv
// Fetch-PC generator: registered fetch address with valid/ready handoff, trap/branch redirects and epoch tagging.
// Redirect-to-fetch latency 1 cycle; i_ready only gates sequential advance; all outputs registered.
module pc_gen #(
   parameter int unsigned          XLEN       = 32,
   parameter logic [XLEN-1:0]      RESET_VEC  = 32'h3000_0000,
   parameter int unsigned          STEP       = 4,
   parameter int unsigned          ALIGN_BITS = 2,
   parameter int unsigned          EPOCH_W    = 2
) (
   input  logic                i_clock,
   input  logic                reset,
   input  logic                i_redir_valid,
   input  logic [XLEN-1:0]     i_redir_pc,
   input  logic                i_trap_valid,
   input  logic [XLEN-1:0]     i_trap_pc,
   input  logic                i_ready,
   output logic                o_valid,
   output logic [XLEN-1:0]     o_pc,
   output logic [EPOCH_W-1:0]  o_epoch,
   output logic                o_misalign
);

   localparam logic [1:0] BOOT = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] HALT = 2'd2;

   localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'((64'd1 << ALIGN_BITS) - 64'd1);
   localparam logic [XLEN-1:0] STEP_INC   = XLEN'(STEP);

   logic [1:0]         state_q,    state_d;
   logic [XLEN-1:0]    pc_q,       pc_d;
   logic               valid_q,    valid_d;
   logic [EPOCH_W-1:0] epoch_q,    epoch_d;
   logic               misalign_q, misalign_d;

   logic               redir_any;
   logic [XLEN-1:0]    redir_tgt;
   logic               xfer;

   // Trap outranks branch when both pulse together.
   assign redir_any = i_trap_valid | i_redir_valid;
   assign redir_tgt = i_trap_valid ? i_trap_pc : i_redir_pc;
   assign xfer      = valid_q & i_ready;

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      valid_d    = valid_q;
      epoch_d    = epoch_q;
      misalign_d = misalign_q;
      if (redir_any) begin
         state_d    = RUN;
         pc_d       = redir_tgt;
         valid_d    = 1'b1;
         epoch_d    = epoch_q + 1'b1;
         misalign_d = (redir_tgt & ALIGN_MASK) != '0;
      end else begin
         case (state_q)
            BOOT: begin
               state_d = RUN;
               valid_d = 1'b1;
            end
            RUN: begin
               if (xfer) begin
                  // A misaligned PC is handed over once so the backend can fault, then fetch stops.
                  if (misalign_q) begin
                     state_d = HALT;
                     valid_d = 1'b0;
                  end else begin
                     pc_d = pc_q + STEP_INC;
                  end
               end
            end
            HALT: begin
               valid_d = 1'b0;
            end
            default: begin
               state_d = BOOT;
               valid_d = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clock) begin
      if (reset) begin
         state_q    <= BOOT;
         pc_q       <= RESET_VEC;
         valid_q    <= 1'b0;
         epoch_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         valid_q    <= valid_d;
         epoch_q    <= epoch_d;
         misalign_q <= misalign_d;
      end
   end

   assign o_valid    = valid_q;
   assign o_pc       = pc_q;
   assign o_epoch    = epoch_q;
   assign o_misalign = misalign_q;

endmodule

// File: tb/tb_pc_gen.sv
// Testbench for pc_gen: directed scenarios plus randomized traffic against a behavioural model.
module tb_pc_gen;

   localparam logic [31:0] RV = 32'h3000_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        redir_v, trap_v, ready;
   logic [31:0] redir_pc, trap_pc;
   logic        o_valid, o_misalign;
   logic [31:0] o_pc;
   logic [1:0]  o_epoch;

   int tests = 0;
   int fails = 0;

   // Behavioural model of what the fetch stage should see.
   logic [31:0] m_pc;
   logic        m_valid, m_mis, m_boot, m_halt;
   int          m_epoch;

   always #5 clk = ~clk;

   pc_gen dut (
      .i_clock      (clk),
      .reset        (reset),
      .i_redir_valid(redir_v),
      .i_redir_pc   (redir_pc),
      .i_trap_valid (trap_v),
      .i_trap_pc    (trap_pc),
      .i_ready      (ready),
      .o_valid      (o_valid),
      .o_pc         (o_pc),
      .o_epoch      (o_epoch),
      .o_misalign   (o_misalign)
   );

   task automatic tick();
      logic [31:0] n_pc;
      logic        n_valid, n_mis, n_boot, n_halt;
      logic [31:0] tgt;
      int          n_epoch;
      n_pc = m_pc; n_valid = m_valid; n_mis = m_mis; n_boot = m_boot;
      n_halt = m_halt; n_epoch = m_epoch;
      if (reset) begin
         n_pc = RV; n_valid = 0; n_mis = 0; n_epoch = 0; n_boot = 1; n_halt = 0;
      end else if (trap_v || redir_v) begin
         tgt = trap_v ? trap_pc : redir_pc;
         n_pc = tgt; n_valid = 1; n_epoch = (m_epoch + 1) % 4;
         n_mis = (tgt % 4) != 0; n_boot = 0; n_halt = 0;
      end else if (m_boot) begin
         n_boot = 0; n_valid = 1;
      end else if (!m_halt && ready) begin
         if (m_mis) begin
            n_halt = 1; n_valid = 0;
         end else begin
            n_pc = m_pc + 32'd4;
         end
      end
      @(posedge clk);
      #1;
      m_pc = n_pc; m_valid = n_valid; m_mis = n_mis; m_boot = n_boot;
      m_halt = n_halt; m_epoch = n_epoch;
   endtask

   task automatic idle_inputs();
      redir_v = 0; trap_v = 0; redir_pc = '0; trap_pc = '0;
   endtask

   task automatic test_reset();
      reset = 1; ready = 1; idle_inputs();
      tick(); tick();
      tests++;
      if (o_valid !== 1'b0 || o_pc !== RV || o_epoch !== 2'd0 || o_misalign !== 1'b0) begin
         fails++;
         $display("FAIL reset_values: valid=%b pc=%h epoch=%0d mis=%b, want 0 %h 0 0",
                  o_valid, o_pc, o_epoch, o_misalign, RV);
      end
      reset = 0;
      tick();
      tests++;
      if (o_valid !== 1'b1 || o_pc !== RV || o_epoch !== 2'd0) begin
         fails++;
         $display("FAIL first_fetch: valid=%b pc=%h epoch=%0d, want 1 %h 0", o_valid, o_pc, o_epoch, RV);
      end
      for (int i = 1; i <= 2; i++) begin
         tick();
         tests++;
         if (o_valid !== 1'b1 || o_pc !== RV + 32'(4 * i) || o_epoch !== 2'd0) begin
            fails++;
            $display("FAIL seq_step%0d: valid=%b pc=%h epoch=%0d, want 1 %h 0",
                     i, o_valid, o_pc, o_epoch, RV + 32'(4 * i));
         end
      end
   endtask

   task automatic test_backpressure();
      ready = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         tests++;
         if (o_pc !== 32'h3000_0008 || o_valid !== 1'b1) begin
            fails++;
            $display("FAIL backpressure_hold%0d: pc=%h valid=%b, want 30000008 1", i, o_pc, o_valid);
         end
      end
      ready = 1;
      tick();
      tests++;
      if (o_pc !== 32'h3000_000C) begin
         fails++;
         $display("FAIL backpressure_resume: pc=%h, want 3000000c", o_pc);
      end
   endtask

   task automatic test_simultaneous();
      ready = 1;
      redir_v = 1; redir_pc = 32'h8000_0100;
      trap_v  = 1; trap_pc  = 32'h8000_0000;
      tick();
      idle_inputs();
      tests++;
      if (o_pc !== 32'h8000_0000 || o_epoch !== 2'd1 || o_valid !== 1'b1 || o_misalign !== 1'b0) begin
         fails++;
         $display("FAIL trap_priority: pc=%h epoch=%0d valid=%b mis=%b, want 80000000 1 1 0",
                  o_pc, o_epoch, o_valid, o_misalign);
      end
   endtask

   task automatic test_misalign();
      ready = 0;
      redir_v = 1; redir_pc = 32'h8000_0102;
      tick();
      idle_inputs();
      tests++;
      if (o_pc !== 32'h8000_0102 || o_misalign !== 1'b1 || o_valid !== 1'b1 || o_epoch !== 2'd2) begin
         fails++;
         $display("FAIL misalign_present: pc=%h mis=%b valid=%b epoch=%0d, want 80000102 1 1 2",
                  o_pc, o_misalign, o_valid, o_epoch);
      end
      ready = 1;
      for (int i = 0; i < 6; i++) begin
         tick();
         tests++;
         if (o_valid !== 1'b0 || o_pc !== 32'h8000_0102 || o_misalign !== 1'b1) begin
            fails++;
            $display("FAIL halt_hold%0d: valid=%b pc=%h mis=%b, want 0 80000102 1",
                     i, o_valid, o_pc, o_misalign);
         end
      end
      trap_v = 1; trap_pc = 32'h8000_0000;
      tick();
      idle_inputs();
      tests++;
      if (o_valid !== 1'b1 || o_misalign !== 1'b0 || o_pc !== 32'h8000_0000 || o_epoch !== 2'd3) begin
         fails++;
         $display("FAIL halt_exit: valid=%b mis=%b pc=%h epoch=%0d, want 1 0 80000000 3",
                  o_valid, o_misalign, o_pc, o_epoch);
      end
   endtask

   task automatic test_wrap();
      ready = 0;
      redir_v = 1; redir_pc = 32'hFFFF_FFFC;
      tick();
      idle_inputs();
      tests++;
      if (o_pc !== 32'hFFFF_FFFC || o_epoch !== 2'd0) begin
         fails++;
         $display("FAIL wrap_target: pc=%h epoch=%0d, want fffffffc 0", o_pc, o_epoch);
      end
      ready = 1;
      tick();
      tests++;
      if (o_pc !== 32'h0000_0000 || o_valid !== 1'b1) begin
         fails++;
         $display("FAIL pc_wrap: pc=%h valid=%b, want 00000000 1", o_pc, o_valid);
      end
      for (int k = 1; k <= 5; k++) begin
         redir_v = 1; redir_pc = 32'h0000_1000 + 32'(16 * k);
         tick();
         idle_inputs();
         tests++;
         if (o_epoch !== 2'(k % 4) || o_pc !== 32'h0000_1000 + 32'(16 * k)) begin
            fails++;
            $display("FAIL epoch_wrap%0d: epoch=%0d pc=%h, want %0d %h",
                     k, o_epoch, o_pc, k % 4, 32'h0000_1000 + 32'(16 * k));
         end
      end
   endtask

   task automatic test_reset_mid();
      ready = 1;
      reset = 1;
      redir_v = 1; redir_pc = 32'h8000_0200;
      tick();
      idle_inputs();
      tests++;
      if (o_valid !== 1'b0 || o_pc !== RV || o_epoch !== 2'd0 || o_misalign !== 1'b0) begin
         fails++;
         $display("FAIL reset_drops_redirect: valid=%b pc=%h epoch=%0d mis=%b, want 0 %h 0 0",
                  o_valid, o_pc, o_epoch, o_misalign, RV);
      end
      reset = 0;
      tick();
      tests++;
      if (o_valid !== 1'b1 || o_pc !== RV) begin
         fails++;
         $display("FAIL reboot: valid=%b pc=%h, want 1 %h", o_valid, o_pc, RV);
      end
   endtask

   task automatic test_random();
      int errs = 0;
      for (int i = 0; i < 600; i++) begin
         ready    = ($urandom_range(3) != 0);
         redir_v  = ($urandom_range(7) == 0);
         trap_v   = ($urandom_range(15) == 0);
         redir_pc = {$urandom_range(255), 24'h0} | ($urandom & 32'h00FF_FFFC)
                    | (($urandom_range(5) == 0) ? 32'($urandom_range(3)) : 32'd0);
         trap_pc  = ($urandom & 32'hFFFF_FFF0) | (($urandom_range(7) == 0) ? 32'd2 : 32'd0);
         reset    = ($urandom_range(99) == 0);
         tick();
         tests++;
         if (o_valid !== m_valid || o_pc !== m_pc || o_epoch !== 2'(m_epoch) || o_misalign !== m_mis) begin
            fails++;
            errs++;
            if (errs <= 10)
               $display("FAIL random_cycle%0d: valid=%b pc=%h epoch=%0d mis=%b, want %b %h %0d %b",
                        i, o_valid, o_pc, o_epoch, o_misalign, m_valid, m_pc, m_epoch, m_mis);
         end
      end
      reset = 0; idle_inputs();
   endtask

   initial begin
      reset = 1; ready = 0; idle_inputs();
      m_pc = RV; m_valid = 0; m_mis = 0; m_boot = 1; m_halt = 0; m_epoch = 0;
      test_reset();
      test_backpressure();
      test_simultaneous();
      test_misalign();
      test_wrap();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
